i2c_target_rx: RTL and testbench
================================

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h24, the 7-bit target address this block answers.
REQ-002 SHALL have port clk_i, input, 1 bit, the single system clock.
REQ-003 SHALL have port sync_reset_i, input, 1 bit, reset (synchronous, active-high).
REQ-004 SHALL have port scl_i, input, 1 bit, bus SCL (asynchronous to clk_i).
REQ-005 SHALL have port sda_in, input, 1 bit, bus SDA level (asynchronous to clk_i).
REQ-006 SHALL have port sda_out, output, 1 bit, SDA drive value, constant 0.
REQ-007 SHALL have port sda_out_en, output, 1 bit; 1 pulls SDA low (ACK).
REQ-008 SHALL have port data_o, output, 8 bits, last received data byte.
REQ-009 SHALL have port data_valid_o, output, 1 bit, one-cycle pulse when data_o updates.
REQ-010 SHALL have port byte_idx_o, output, 4 bits, index of data_o within the current transfer, counting from 0.
REQ-011 SHALL have port busy_o, output, 1 bit, high from an addressed START until STOP.

Function
REQ-012 SHALL pass scl_i and sda_in through 2-FF synchronizers, plus one history register, before any use.
REQ-013 SHALL detect START as synchronized SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1.
REQ-014 SHALL sample SDA on the synchronized SCL rising edge, MSB first.
REQ-015 SHALL implement these FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-016 SHALL move from IDLE to ADDR on START; other bus activity in IDLE is ignored.
REQ-017 SHALL, after 8 bits in ADDR, go to ADDR_ACK if bits[7:1]==DEV_ADDR and R/W=0; otherwise go to IGNORE with SDA released.
REQ-018 SHALL treat read requests (R/W=1) as non-matching; this block is write-only.
REQ-019 SHALL assert sda_out_en on the synchronized SCL falling edge after the 8th bit, hold it through the 9th SCL high, and release it on the following SCL falling edge.
REQ-020 SHALL go from ADDR_ACK to DATA, and from DATA_ACK to DATA, when sda_out_en is released.
REQ-021 SHALL, after 8 bits in DATA: load data_o, pulse data_valid_o for exactly one clk_i cycle coincident with sda_out_en rising, and enter DATA_ACK.
REQ-022 SHALL set byte_idx_o to 0 for the first data byte after an address; it increments per byte and saturates at 15.
REQ-023 SHALL ACK every data byte; there is no backpressure, and data_o holds until overwritten.
REQ-024 SHALL return to IDLE on STOP from any state, releasing SDA and clearing busy_o in the same cycle.
REQ-025 SHALL go to ADDR on a repeated START in any state, clear the bit counter, and leave data_o unchanged.
REQ-026 SHALL discard a partial byte (fewer than 8 bits) that is aborted by START or STOP, with no data_valid_o pulse.
REQ-027 SHALL never assert sda_out_en outside ADDR_ACK or DATA_ACK.

Reset
REQ-028 SHALL, while sync_reset_i=1 at a clk_i edge, force: FSM=IDLE, sda_out_en=0, data_o=8'h00, data_valid_o=0, byte_idx_o=0, busy_o=0, bit counter=0, synchronizers=1.
REQ-029 SHALL, on reset mid-transfer, release SDA on the next clk_i edge and ignore the bus until the next START.

Structure
REQ-030 SHALL define the FSM state enum and the I2C bit-count constant (8) in shared package i2c_pkg.
REQ-031 SHALL use one sub-module, i2c_bus_sync, which synchronizes SCL/SDA and emits scl_rise, scl_fall, start_det and stop_det pulses.

Verification
REQ-032 SHALL cover: START, addr 0x48 (0x24 write), data 0x3F, 0x06, STOP -> ACK on all 3 bytes; data_valid_o pulses twice with data_o 0x3F (idx 0) then 0x06 (idx 1); busy_o drops at STOP.
REQ-033 SHALL cover: addr byte 0x4A (wrong address) followed by 2 bytes -> sda_out_en stays 0 throughout; no data_valid_o.
REQ-034 SHALL cover: addr byte 0x49 (read request) -> NACK; FSM=IGNORE until STOP.
REQ-035 SHALL cover: START, 0x48, 4 bits of 0xA_, repeated START, 0x48, 0x5B, STOP -> a single data_valid_o with 0x5B at idx 0.
REQ-036 SHALL cover: sync_reset_i pulsed during the ACK of byte 1 -> sda_out_en=0 the next cycle; no ACK and no data_valid_o until a fresh START.
REQ-037 SHALL cover: 20 data bytes in one transfer -> byte_idx_o reaches 15 and holds there; all 20 bytes ACKed.

Source files
------------

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the write-only I2C target receiver:
//   I2C_BITS     - data/address bits per I2C byte (8)
//   BIT_CNT_FULL - I2C_BITS sized to match the receiver's bit counter
//   i2c_state_e  - receiver FSM states
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int unsigned I2C_BITS     = 8;
  localparam logic [3:0]  BIT_CNT_FULL = 4'(I2C_BITS);

  typedef enum logic [2:0] {
    IDLE,      // not addressed, waiting for START
    ADDR,      // shifting in the address byte
    ADDR_ACK,  // driving ACK for our address
    DATA,      // shifting in a data byte
    DATA_ACK,  // driving ACK for a data byte
    IGNORE     // someone else's transfer (or a read), wait for START/STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings the asynchronous SCL/SDA lines into the clk_i domain through two
// flops each, keeps one extra history flop per line, and decodes bus events.
// Ports:
//   clk_i, sync_reset_i - system clock, synchronous active-high reset
//   scl_i, sda_in       - raw bus lines
//   sda_bit             - synchronized SDA level (sampled by the receiver)
//   scl_rise, scl_fall  - one-cycle pulses on synchronized SCL edges
//   start_det, stop_det - one-cycle pulses on START / STOP conditions
// ---------------------------------------------------------------------------
module i2c_bus_sync (
  input  logic clk_i,
  input  logic sync_reset_i,
  input  logic scl_i,
  input  logic sda_in,
  output logic sda_bit,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta, scl_sync, scl_hist;
  logic sda_meta, sda_sync, sda_hist;

  // Reset to 1 (the idle bus level) so leaving reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (sync_reset_i) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_hist <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take its neighbour's
      // pre-edge value, so this really is a three-stage shift chain.
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
      scl_hist <= scl_sync;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;
      sda_hist <= sda_sync;
    end
  end

  assign sda_bit  = sda_sync;
  assign scl_rise = scl_sync & ~scl_hist;
  assign scl_fall = ~scl_sync & scl_hist;

  // SDA may only change while SCL is high for START/STOP; requiring SCL
  // high on both samples keeps an SCL edge from being read as one.
  assign start_det = scl_sync & scl_hist & sda_hist & ~sda_sync;
  assign stop_det  = scl_sync & scl_hist & ~sda_hist & sda_sync;

endmodule

// File: rtl/i2c_target_rx.sv
// ---------------------------------------------------------------------------
// i2c_target_rx
// Write-only I2C target. Answers DEV_ADDR with R/W=0, ACKs every data byte
// and presents each received byte with its index in the transfer.
// Ports:
//   clk_i, sync_reset_i - system clock, synchronous active-high reset
//   scl_i, sda_in       - bus lines (asynchronous to clk_i)
//   sda_out, sda_out_en - open-drain SDA drive (value always 0, enable = ACK)
//   data_o              - last received data byte (held until overwritten)
//   data_valid_o        - one-cycle pulse when data_o updates
//   byte_idx_o          - index of data_o in the transfer, saturates at 15
//   busy_o              - high from an addressed START until STOP
// ---------------------------------------------------------------------------
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h24
) (
  input  logic       clk_i,
  input  logic       sync_reset_i,
  input  logic       scl_i,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_out_en,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic [3:0] byte_idx_o,
  output logic       busy_o
);

  logic sda_bit, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_bus_sync (
    .clk_i       (clk_i),
    .sync_reset_i(sync_reset_i),
    .scl_i       (scl_i),
    .sda_in      (sda_in),
    .sda_bit     (sda_bit),
    .scl_rise    (scl_rise),
    .scl_fall    (scl_fall),
    .start_det   (start_det),
    .stop_det    (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [3:0] next_idx_q;
  logic       byte_done;
  logic       addr_match;

  assign byte_done  = (bit_cnt_q == BIT_CNT_FULL);
  // Reads (R/W=1) are treated as a non-matching address.
  assign addr_match = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is
    // inferred.
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:     if (scl_fall && byte_done) state_d = addr_match ? ADDR_ACK : IGNORE;
        DATA:     if (scl_fall && byte_done) state_d = DATA_ACK;
        ADDR_ACK,
        DATA_ACK: if (scl_fall) state_d = DATA;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_reset_i) begin
      state_q      <= IDLE;
      sda_out_en   <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      next_idx_q   <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      byte_idx_o   <= '0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Registered from the next state so the ACK drive is glitch-free and
      // can only be high while the FSM sits in an ACK state.
      sda_out_en   <= (state_d == ADDR_ACK) || (state_d == DATA_ACK);
      data_valid_o <= 1'b0;

      // Any state change or START restarts the byte; a partial byte is
      // simply dropped.
      if (start_det || (state_d != state_q)) begin
        bit_cnt_q <= '0;
      end else if ((state_q == ADDR || state_q == DATA) && scl_rise && !byte_done) begin
        shift_q   <= {shift_q[6:0], sda_bit};
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end

      if (state_q == ADDR && state_d == ADDR_ACK) begin
        next_idx_q <= '0;
        busy_o     <= 1'b1;
      end

      // Byte delivery coincides with the rising ACK enable.
      if (state_q == DATA && state_d == DATA_ACK) begin
        data_o       <= shift_q;
        data_valid_o <= 1'b1;
        byte_idx_o   <= next_idx_q;
        if (next_idx_q != 4'hF) next_idx_q <= next_idx_q + 4'd1;
      end

      if (stop_det) busy_o <= 1'b0;
    end
  end

  assign sda_out = 1'b0;

endmodule

// File: tb/tb_i2c_target_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_rx
// Drives I2C write transfers into i2c_target_rx and checks it against a
// byte-level model of the target's behaviour.
// ---------------------------------------------------------------------------
module tb_i2c_target_rx;
  import i2c_pkg::*;

  localparam logic [6:0] DEV = 7'h24;
  localparam int         T   = 50;   // quarter SCL period (5 clk cycles)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_out, sda_out_en, data_valid_o, busy_o;
  logic [7:0] data_o;
  logic [3:0] byte_idx_o;

  assign sda_bus = m_sda & ~sda_out_en;

  always #5 clk = ~clk;

  i2c_target_rx #(.DEV_ADDR(DEV)) dut (
    .clk_i       (clk),
    .sync_reset_i(rst),
    .scl_i       (m_scl),
    .sda_in      (sda_bus),
    .sda_out     (sda_out),
    .sda_out_en  (sda_out_en),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .byte_idx_o  (byte_idx_o),
    .busy_o      (busy_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transfer / byte level) -------------
  typedef enum {P_IDLE, P_ADDR, P_DATA, P_IGNORE} phase_e;
  typedef struct {logic [7:0] d; logic [3:0] idx;} rec_t;

  phase_e     phase = P_IDLE;
  int         nbits = 0;
  logic [7:0] acc = '0;
  int         m_idx = 0;
  bit         m_busy = 0;
  bit         exp_ack = 0;
  bit         ack_ok = 0;     // target may drive SDA only while this is set
  rec_t       exp_q[$];
  rec_t       log_q[$];
  int         sda_en_cycles = 0;
  int         ack_count = 0;

  task automatic m_on_start();
    phase = P_ADDR;
    nbits = 0;
  endtask

  task automatic m_on_stop();
    phase  = P_IDLE;
    nbits  = 0;
    m_busy = 0;
  endtask

  task automatic m_on_bit(input logic b);
    if (phase == P_ADDR || phase == P_DATA) begin
      acc = {acc[6:0], b};
      nbits++;
      if (nbits == 8) begin
        nbits = 0;
        if (phase == P_ADDR) begin
          exp_ack = (acc[7:1] == DEV) && !acc[0];
          if (exp_ack) begin
            phase  = P_DATA;
            m_idx  = 0;
            m_busy = 1;
          end else begin
            phase = P_IGNORE;
          end
        end else begin
          exp_ack = 1;
          exp_q.push_back('{acc, 4'(m_idx)});
          if (m_idx < 15) m_idx++;
        end
        ack_ok = exp_ack;
      end
    end
  endtask

  // ---------------- per-cycle compare -------------------------------------
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (data_valid_o) begin
      check("valid_on_ack_rise", 32'({prev_en, sda_out_en}), 32'(2'b01));
      check("valid_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        rec_t e;
        e = exp_q.pop_front();
        check("data_o", 32'(data_o), 32'(e.d));
        check("byte_idx_o", 32'(byte_idx_o), 32'(e.idx));
      end
      log_q.push_back('{data_o, byte_idx_o});
    end
    if (!ack_ok) check("sda_en_outside_ack", 32'(sda_out_en), 32'(0));
    check("sda_out_zero", 32'(sda_out), 32'(0));
    if (sda_out_en) sda_en_cycles++;
    prev_en = sda_out_en;
  end

  // ---------------- bus master --------------------------------------------
  task automatic bus_start();
    m_sda = 1'b1; #T;
    m_scl = 1'b1; #T;
    m_sda = 1'b0; m_on_start(); #T;
    m_scl = 1'b0; #T;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #T;
    m_scl = 1'b1; #T;
    m_sda = 1'b1; m_on_stop(); #T;
    check("busy_after_stop", 32'(busy_o), 32'(0));
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; m_on_bit(b); #T;
    m_scl = 1'b1; #(2*T);
    m_scl = 1'b0; #T;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[7-i]);
  endtask

  task automatic ack_slot(input bit do_rst);
    m_sda = 1'b1; #T;
    m_scl = 1'b1; #T;
    check("ack_level", 32'(sda_bus), 32'(!exp_ack));
    check("busy_in_ack", 32'(busy_o), 32'(m_busy));
    if (sda_bus === 1'b0) ack_count++;
    if (do_rst) begin
      @(negedge clk); #1;
      rst = 1'b1; ack_ok = 0; exp_ack = 0; phase = P_IDLE; m_busy = 0; nbits = 0;
      @(posedge clk); #1;
      check("rst_drops_sda_en", 32'(sda_out_en), 32'(0));
      rst = 1'b0;
    end
    #T;
    m_scl = 1'b0; #T;
    ack_ok  = 0;
    exp_ack = 0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
    ack_slot(0);
  endtask

  // ---------------- stimulus ----------------------------------------------
  int base_log, base_ack, base_en;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_en", 32'(sda_out_en), 32'(0));
    check("rst_data", 32'(data_o), 32'(0));
    check("rst_valid", 32'(data_valid_o), 32'(0));
    check("rst_idx", 32'(byte_idx_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    #(2*T);

    // Basic write: address + two data bytes.
    base_log = log_q.size(); base_ack = ack_count;
    bus_start();
    send_byte(8'h48);
    send_byte(8'h3F);
    send_byte(8'h06);
    check("s1_busy_mid", 32'(busy_o), 32'(1));
    bus_stop();
    check("s1_acks", 32'(ack_count - base_ack), 32'(3));
    check("s1_nvalid", 32'(log_q.size() - base_log), 32'(2));
    if (log_q.size() >= base_log + 2) begin
      check("s1_byte0", 32'(log_q[base_log].d), 32'(8'h3F));
      check("s1_idx0", 32'(log_q[base_log].idx), 32'(0));
      check("s1_byte1", 32'(log_q[base_log+1].d), 32'(8'h06));
      check("s1_idx1", 32'(log_q[base_log+1].idx), 32'(1));
    end
    #(2*T);

    // Wrong address: never drives SDA, never delivers.
    base_log = log_q.size(); base_en = sda_en_cycles;
    bus_start();
    send_byte(8'h4A);
    send_byte(8'hC3);
    send_byte(8'h18);
    bus_stop();
    check("s2_no_sda_en", 32'(sda_en_cycles - base_en), 32'(0));
    check("s2_no_valid", 32'(log_q.size() - base_log), 32'(0));
    #(2*T);

    // Read request: NACK, ignored until STOP.
    base_ack = ack_count;
    bus_start();
    send_byte(8'h49);
    check("s3_nack", 32'(ack_count - base_ack), 32'(0));
    check("s3_state_ignore", 32'(dut.state_q), 32'(IGNORE));
    send_byte(8'h55);
    check("s3_still_ignore", 32'(dut.state_q), 32'(IGNORE));
    bus_stop();
    check("s3_state_idle", 32'(dut.state_q), 32'(IDLE));
    #(2*T);

    // Partial byte aborted by repeated START.
    base_log = log_q.size();
    bus_start();
    send_byte(8'h48);
    send_bits(8'hA0, 4);
    bus_start();
    send_byte(8'h48);
    send_byte(8'h5B);
    bus_stop();
    check("s4_nvalid", 32'(log_q.size() - base_log), 32'(1));
    if (log_q.size() > base_log) begin
      check("s4_data", 32'(log_q[base_log].d), 32'(8'h5B));
      check("s4_idx", 32'(log_q[base_log].idx), 32'(0));
    end
    #(2*T);

    // Reset during the address ACK: silent until a fresh START.
    bus_start();
    send_bits(8'h48, 8);
    ack_slot(1);
    base_log = log_q.size(); base_ack = ack_count;
    send_byte(8'h11);
    send_byte(8'h22);
    bus_stop();
    check("s5_no_ack", 32'(ack_count - base_ack), 32'(0));
    check("s5_no_valid", 32'(log_q.size() - base_log), 32'(0));
    bus_start();
    send_byte(8'h48);
    send_byte(8'h77);
    bus_stop();
    check("s5_recover_n", 32'(log_q.size() - base_log), 32'(1));
    if (log_q.size() > base_log) begin
      check("s5_recover_data", 32'(log_q[base_log].d), 32'(8'h77));
      check("s5_recover_idx", 32'(log_q[base_log].idx), 32'(0));
    end
    #(2*T);

    // Long transfer: index saturates at 15.
    base_log = log_q.size(); base_ack = ack_count;
    bus_start();
    send_byte(8'h48);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    bus_stop();
    check("s6_acks", 32'(ack_count - base_ack), 32'(21));
    check("s6_nvalid", 32'(log_q.size() - base_log), 32'(20));
    if (log_q.size() >= base_log + 20) begin
      check("s6_idx14", 32'(log_q[base_log+14].idx), 32'(14));
      check("s6_idx15", 32'(log_q[base_log+15].idx), 32'(15));
      check("s6_idx19", 32'(log_q[base_log+19].idx), 32'(15));
    end
    #(2*T);

    // Random transfers: mixed addresses, lengths, aborts, repeated STARTs.
    for (int t = 0; t < 25; t++) begin
      logic [7:0] a;
      int         n;
      a = ($urandom_range(0, 1) == 1) ? {DEV, 1'b0} : 8'($urandom);
      n = $urandom_range(0, 4);
      bus_start();
      send_byte(a);
      for (int i = 0; i < n; i++) send_byte(8'($urandom));
      if ($urandom_range(0, 2) == 0) send_bits(8'($urandom), $urandom_range(1, 7));
      if ($urandom_range(0, 9) < 7) begin
        bus_stop();
        #(2*T);
      end
    end
    bus_stop();
    #(4*T);

    check("exp_queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
